// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweeper: FSM state encoding,
// reference truth tables for common 2-input gates, and a width helper.
package gate_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } sweep_state_t;

   // Bit i is the expected gate output when the gate input equals i.
   localparam logic [3:0] TRUTH_OR   = 4'b1110;
   localparam logic [3:0] TRUTH_AND  = 4'b1000;
   localparam logic [3:0] TRUTH_XOR  = 4'b0110;
   localparam logic [3:0] TRUTH_NAND = 4'b0111;

   // The mismatch count must hold 2^n_inputs, which needs one extra bit.
   function automatic int err_count_width(input int n_inputs);
      return n_inputs + 1;
   endfunction

endpackage

// File: rtl/sweep_settle_counter.sv
// Loadable down-counter used to hold each vector for a fixed number of
// cycles. It stops at zero and reports zero combinationally.
module sweep_settle_counter #(
   parameter int W    = 1,
   parameter int LOAD = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic zero
);

   logic [W-1:0] cnt;

   // Load takes priority over counting; the counter never wraps below zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= W'(LOAD);
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/gate_sweeper.sv
// Stimulus sequencer for a combinational gate: drives every input vector in
// ascending order, holds each for SETTLE cycles plus one sample cycle,
// compares the gate output against TRUTH and reports the result.
//
// start is a one-cycle request; it is honoured only while not busy
// (IDLE or DONE) and is silently dropped otherwise, with no queuing.
module gate_sweeper
   import gate_sweep_pkg::*;
#(
   parameter int                      N_INPUTS = 2,
   parameter logic [2**N_INPUTS-1:0]  TRUTH    = TRUTH_OR,
   parameter int                      SETTLE   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                dut_out,
   output logic [N_INPUTS-1:0] dut_in,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [N_INPUTS:0]   err_count,
   output logic                first_fail_valid,
   output logic [N_INPUTS-1:0] first_fail_vec
);

   localparam int NV = 2**N_INPUTS;
   localparam int EW = err_count_width(N_INPUTS);
   localparam logic [N_INPUTS-1:0] LAST_VEC = N_INPUTS'(NV - 1);
   // Counter only needs to hold SETTLE-1; keep at least one bit.
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   sweep_state_t          state;
   sweep_state_t          state_next;
   logic [N_INPUTS-1:0]   vec;
   logic                  accept;
   logic                  cnt_load;
   logic                  cnt_en;
   logic                  cnt_zero;
   logic                  last_vec;
   logic                  mismatch;

   assign last_vec = (vec == LAST_VEC);
   // X/Z on the gate output is treated as a failure, hence the case-inequality.
   assign mismatch = (dut_out !== TRUTH[vec]);

   sweep_settle_counter #(
      .W    (CW),
      .LOAD (SETTLE - 1)
   ) u_settle_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .en    (cnt_en),
      .zero  (cnt_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: hold each vector until the settle counter expires,
   // sample once, then advance or finish.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (start) state_next = ST_SETTLE;
         ST_SETTLE: if (cnt_zero) state_next = ST_SAMPLE;
         ST_SAMPLE: state_next = last_vec ? ST_DONE : ST_SETTLE;
         ST_DONE:   if (start) state_next = ST_SETTLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Output and control decode from the current state.
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      pass     = 1'b0;
      accept   = 1'b0;
      cnt_en   = 1'b0;
      cnt_load = 1'b0;
      case (state)
         ST_IDLE: begin
            accept   = start;
            cnt_load = start;
         end
         ST_SETTLE: begin
            busy   = 1'b1;
            cnt_en = 1'b1;
         end
         ST_SAMPLE: begin
            busy     = 1'b1;
            cnt_load = !last_vec;
         end
         ST_DONE: begin
            done     = 1'b1;
            pass     = (err_count == '0);
            accept   = start;
            cnt_load = start;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Sweep datapath: vector register, mismatch count, first-failure capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec              <= '0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else if (accept) begin
         vec              <= '0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else if (state == ST_SAMPLE) begin
         if (mismatch) begin
            err_count <= err_count + EW'(1);
            if (!first_fail_valid) begin
               first_fail_valid <= 1'b1;
               first_fail_vec   <= vec;
            end
         end
         if (!last_vec) begin
            vec <= vec + N_INPUTS'(1);
         end
      end
   end

   assign dut_in = vec;

endmodule

// File: tb/tb_gate_sweeper.sv
// Bench for gate_sweeper: three instances (OR table, AND table, 3-input AND
// with SETTLE=1) each driving a bench-side gate model whose behaviour is
// selected per sweep. A timeline model predicts every output each cycle.
module tb_gate_sweeper;
   import gate_sweep_pkg::*;

   // Gate behaviours offered by the bench-side gate under test.
   localparam int G_OR = 0, G_STUCK0 = 1, G_AND = 2, G_NAND = 3;

   logic clk;
   logic rst_n;
   logic start_a, start_b, start_c;
   int   mode_a, mode_b, mode_c;
   logic out_a, out_b, out_c;

   logic [1:0] in_a, ffvec_a, in_b, ffvec_b;
   logic [2:0] err_a, err_b, in_c, ffvec_c;
   logic [3:0] err_c;
   logic busy_a, done_a, pass_a, ffv_a;
   logic busy_b, done_b, pass_b, ffv_b;
   logic busy_c, done_c, pass_c, ffv_c;

   int n_checks = 0;
   int n_fail   = 0;
   int t_a = -1, t_b = -1, t_c = -1;
   int smode_a = 0, smode_b = 0, smode_c = 0;
   int bcnt_a = 0, bcnt_c = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- gate under test models ----------------
   function automatic bit gate_val(input int mode, input int n, input int v);
      case (mode)
         G_OR:     return (v != 0);
         G_STUCK0: return 1'b0;
         G_AND:    return (v == (1 << n) - 1);
         G_NAND:   return (v != (1 << n) - 1);
         default:  return 1'b0;
      endcase
   endfunction

   assign out_a = gate_val(mode_a, 2, int'(in_a));
   assign out_b = gate_val(mode_b, 2, int'(in_b));
   assign out_c = gate_val(mode_c, 3, int'(in_c));

   gate_sweeper #(.N_INPUTS(2), .TRUTH(TRUTH_OR), .SETTLE(2)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(out_a), .dut_in(in_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
      .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a));

   gate_sweeper #(.N_INPUTS(2), .TRUTH(TRUTH_AND), .SETTLE(2)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(out_b), .dut_in(in_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
      .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b));

   gate_sweeper #(.N_INPUTS(3), .TRUTH(8'b1000_0000), .SETTLE(1)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .dut_out(out_c), .dut_in(in_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
      .first_fail_valid(ffv_c), .first_fail_vec(ffvec_c));

   // ---------------- comparison helper ----------------
   task automatic cmp(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // t = clock edges since the accepting edge (-1: no sweep since reset).
   // Each vector occupies s+1 cycles; its verdict becomes visible after its
   // last cycle, i.e. once t reaches (v+1)*(s+1).
   function automatic bit model_busy(input int t, input int n, input int s);
      return (t >= 0) && (t < (1 << n) * (s + 1));
   endfunction

   task automatic check_inst(input string nm, input int n, input int s, input int truth,
                             input int mode, input int t,
                             input int a_in, input int a_busy, input int a_done,
                             input int a_pass, input int a_err, input int a_ffv,
                             input int a_ffvec);
      int e_in = 0, e_busy = 0, e_done = 0, e_pass = 0;
      int e_err = 0, e_ffv = 0, e_ffvec = 0;
      if (t >= 0) begin
         e_busy = model_busy(t, n, s);
         e_done = !e_busy;
         e_in   = e_busy ? t / (s + 1) : (1 << n) - 1;
         for (int v = 0; v < (1 << n); v++) begin
            if (((v + 1) * (s + 1) <= t) && (int'(gate_val(mode, n, v)) != ((truth >> v) & 1))) begin
               e_err++;
               if (e_ffv == 0) begin
                  e_ffv   = 1;
                  e_ffvec = v;
               end
            end
         end
         e_pass = (e_done != 0) && (e_err == 0);
      end
      cmp({nm, ".dut_in"}, a_in, e_in);
      cmp({nm, ".busy"}, a_busy, e_busy);
      cmp({nm, ".done"}, a_done, e_done);
      cmp({nm, ".pass"}, a_pass, e_pass);
      cmp({nm, ".err_count"}, a_err, e_err);
      cmp({nm, ".first_fail_valid"}, a_ffv, e_ffv);
      cmp({nm, ".first_fail_vec"}, a_ffvec, e_ffvec);
   endtask

   // Model timelines: a start is taken only while the model says not busy.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_a <= -1; t_b <= -1; t_c <= -1;
      end else begin
         if (start_a && !model_busy(t_a, 2, 2)) begin t_a <= 0; smode_a <= mode_a; end
         else if (t_a >= 0 && t_a < 10000) t_a <= t_a + 1;
         if (start_b && !model_busy(t_b, 2, 2)) begin t_b <= 0; smode_b <= mode_b; end
         else if (t_b >= 0 && t_b < 10000) t_b <= t_b + 1;
         if (start_c && !model_busy(t_c, 3, 1)) begin t_c <= 0; smode_c <= mode_c; end
         else if (t_c >= 0 && t_c < 10000) t_c <= t_c + 1;
      end
   end

   // Per-cycle compare of all outputs against the model, away from the edge.
   always @(negedge clk) begin
      check_inst("a", 2, 2, 14, smode_a, t_a, int'(in_a), int'(busy_a), int'(done_a),
                 int'(pass_a), int'(err_a), int'(ffv_a), int'(ffvec_a));
      check_inst("b", 2, 2, 8, smode_b, t_b, int'(in_b), int'(busy_b), int'(done_b),
                 int'(pass_b), int'(err_b), int'(ffv_b), int'(ffvec_b));
      check_inst("c", 3, 1, 128, smode_c, t_c, int'(in_c), int'(busy_c), int'(done_c),
                 int'(pass_c), int'(err_c), int'(ffv_c), int'(ffvec_c));
      if (busy_a) bcnt_a++;
      if (busy_c) bcnt_c++;
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input int idx);
      @(negedge clk); #1;
      case (idx) 0: start_a = 1'b1; 1: start_b = 1'b1; default: start_c = 1'b1; endcase
      @(negedge clk); #1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
   endtask

   function automatic bit get_done(input int idx);
      case (idx) 0: return done_a; 1: return done_b; default: return done_c; endcase
   endfunction

   task automatic wait_done(input int idx);
      int g = 0;
      while (!get_done(idx) && g < 300) begin
         @(negedge clk); #1;
         g++;
      end
      cmp("wait_done", int'(get_done(idx)), 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int g;
      rst_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      mode_a = G_OR; mode_b = G_AND; mode_c = G_AND;
      repeat (3) @(negedge clk);
      #1;
      cmp("reset.busy", int'(busy_a), 0);
      cmp("reset.done", int'(done_a), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Correct OR gate: 12 busy cycles, pass.
      bcnt_a = 0;
      pulse_start(0);
      wait_done(0);
      cmp("or.busy_cycles", bcnt_a, 12);
      cmp("or.pass", int'(pass_a), 1);
      cmp("or.err_count", int'(err_a), 0);
      cmp("or.first_fail_valid", int'(ffv_a), 0);

      // Stuck-at-0 gate against OR table.
      mode_a = G_STUCK0;
      pulse_start(0);
      wait_done(0);
      cmp("stuck0.pass", int'(pass_a), 0);
      cmp("stuck0.err_count", int'(err_a), 3);
      cmp("stuck0.first_fail_valid", int'(ffv_a), 1);
      cmp("stuck0.first_fail_vec", int'(ffvec_a), 1);

      // Restart from DONE: done drops and the old count is cleared.
      mode_a = G_OR;
      pulse_start(0);
      cmp("restart.done", int'(done_a), 0);
      cmp("restart.busy", int'(busy_a), 1);
      cmp("restart.err_count", int'(err_a), 0);
      wait_done(0);
      cmp("restart.pass", int'(pass_a), 1);

      // AND gate against OR table, then against AND table.
      mode_a = G_AND;
      pulse_start(0);
      wait_done(0);
      cmp("and_vs_or.err_count", int'(err_a), 2);
      cmp("and_vs_or.first_fail_vec", int'(ffvec_a), 1);
      pulse_start(1);
      wait_done(1);
      cmp("and_vs_and.pass", int'(pass_b), 1);

      // Reset while the third vector is applied.
      mode_a = G_OR;
      pulse_start(0);
      g = 0;
      while (in_a != 2'd2 && g < 50) begin
         @(negedge clk);
         g++;
      end
      cmp("midreset.reached_vec2", int'(in_a), 2);
      #2 rst_n = 1'b0;
      #1;
      cmp("midreset.dut_in", int'(in_a), 0);
      cmp("midreset.busy", int'(busy_a), 0);
      cmp("midreset.err_count", int'(err_a), 0);
      cmp("midreset.first_fail_valid", int'(ffv_a), 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      cmp("midreset.no_done", int'(done_a), 0);
      cmp("midreset.idle_busy", int'(busy_a), 0);
      pulse_start(0);
      wait_done(0);
      cmp("midreset.rerun_pass", int'(pass_a), 1);

      // start held high and re-pulsed while busy: still one 12-cycle sweep.
      bcnt_a = 0;
      @(negedge clk); #1 start_a = 1'b1;
      repeat (4) @(negedge clk);
      #1 start_a = 1'b0;
      repeat (3) @(negedge clk);
      #1 start_a = 1'b1;
      @(negedge clk);
      #1 start_a = 1'b0;
      wait_done(0);
      cmp("held_start.busy_cycles", bcnt_a, 12);
      repeat (3) @(negedge clk);
      #1;
      cmp("held_start.still_done", int'(done_a), 1);

      // Three-input AND, SETTLE=1: 16 cycles; inverted gate fails every vector.
      bcnt_c = 0;
      pulse_start(2);
      wait_done(2);
      cmp("and3.busy_cycles", bcnt_c, 16);
      cmp("and3.pass", int'(pass_c), 1);
      mode_c = G_NAND;
      pulse_start(2);
      wait_done(2);
      cmp("nand3.err_count", int'(err_c), 8);
      cmp("nand3.first_fail_vec", int'(ffvec_c), 0);
      cmp("nand3.pass", int'(pass_c), 0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gate_sweeper.md
Name: gate_sweeper

Overview:
Self-checking stimulus sequencer for combinational gate blocks such as student_or, student_and and student_xor. It sits directly upstream of the gate under test and drives every input combination in ascending binary order. After each combination settles, it samples the gate output and compares it against a parameterised truth table. It accumulates a mismatch count, records the first failing vector and raises done/pass, replacing hand-written display-only benches.

Parameters:
N_INPUTS, 2, number of gate inputs; vectors 0..2^N_INPUTS-1; legal range 1..6
TRUTH, 4'b1110, expected output per vector, bit i = expected out for dut_in==i; width 2^N_INPUTS; default = OR
SETTLE, 2, clock cycles each vector is held before sampling; legal minimum 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a sweep
dut_out  input  1  output of the gate under test
dut_in  output  N_INPUTS  vector driven into the gate under test
busy  output  1  high while a sweep is in progress
done  output  1  high after a sweep completes; held until the next accepted start
pass  output  1  valid when done; 1 iff err_count==0
err_count  output  N_INPUTS+1  number of mismatching vectors
first_fail_valid  output  1  a mismatch has been recorded this sweep
first_fail_vec  output  N_INPUTS  lowest vector index that mismatched

Behaviour:
- Clocking and reset: single clock, clk; reset is asynchronous and active-low on rst_n. Reset values: dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0. Internally the FSM is IDLE and the settle counter is 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 is accepted on the clock edge. On acceptance: vec<=0, cnt<=SETTLE-1, err_count<=0, first_fail_valid<=0, first_fail_vec<=0, done<=0, pass<=0; go to SETTLE.
- SETTLE: busy=1. cnt decrements each cycle. When cnt==0, go to SAMPLE.
- SAMPLE: busy=1 for exactly one cycle.
  - Mismatch is dut_out != TRUTH[vec]. On mismatch, err_count increments. If first_fail_valid==0, set first_fail_vec<=vec and first_fail_valid<=1.
  - If vec==2^N_INPUTS-1, go to DONE. Otherwise vec<=vec+1, cnt<=SETTLE-1, go to SETTLE.
- DONE: busy=0, done=1, pass=(err_count==0). Results hold indefinitely. start=1 in DONE is accepted exactly as in IDLE (restart).
- Output mapping: dut_in is the vec register, so it changes only on the clock edge leaving SAMPLE. The gate therefore sees each vector stable for SETTLE+1 cycles, including the sample cycle.
- Latency: per vector SETTLE+1 cycles. From the accepting edge to DONE entry is 2^N_INPUTS*(SETTLE+1) cycles. Defaults give 12.
- start while busy=1 is ignored; there is no queuing.
- Width: err_count cannot overflow, since the maximum is 2^N_INPUTS < 2^(N_INPUTS+1). No saturation logic is needed.
- No wrap-around: vec never increments past 2^N_INPUTS-1.
- Reset mid-sweep: all outputs return to reset values immediately (asynchronously). Partial results are discarded. A new start is required after rst_n deasserts.
- dut_out is assumed to be combinationally settled within SETTLE cycles. X on dut_out at sample counts as a mismatch (compare with !==).

Decomposition:
- gate_sweep_pkg holds the state enum (IDLE, SETTLE, SAMPLE, DONE), a TRUTH_OR/AND/XOR/NAND constants set for N_INPUTS=2, and a helper function computing err_count width.
- One sub-module, sweep_settle_counter, is natural: a loadable down-counter with load value SETTLE-1 and a zero flag, reusable for later multi-cycle benches.

Test Plan:
1. Correct OR gate, defaults: pulse start → busy for 12 cycles; dut_in 00,01,10,11 each held 3 cycles; done=1, pass=1, err_count=0, first_fail_valid=0.
2. Gate stuck at 0, TRUTH=1110 → done, pass=0, err_count=3, first_fail_vec=01, first_fail_valid=1.
3. AND gate against OR truth table → err_count=2, first_fail_vec=01; re-run with TRUTH=1000 → pass=1.
4. Drop rst_n during 3rd vector (dut_in=10) → all outputs 0 immediately; no done after release until new start; next sweep gives pass=1.
5. start held high and re-pulsed while busy → single sweep, still 12 cycles; start pulse in DONE → done drops next cycle, new sweep begins, err_count cleared.
6. N_INPUTS=3, SETTLE=1, TRUTH=8'b1000_0000 (3-input AND), correct gate → done after 16 cycles, pass=1; invert gate output → err_count=8, first_fail_vec=000.
